nrisc_mc_sequencer: RTL and testbench
=====================================

// Module: nrisc_mc_sequencer
// PURPOSE
//  Multi-cycle control FSM for the nRISC 8-bit datapath (18-bit instr, opcode = instr[17:15]).
//  Replaces single-cycle decode: sequences FETCH/DECODE/EXEC/MEM/WB, drives all datapath strobes.
//  Adds a req/ack handshake to data memory, run/step/halt debug control and a retired-instr counter.
//  Sits between the instruction register and the PC, register bank, ALU control and data memory.
// PARAMETERS
//  MEM_TIMEOUT    15  max wait cycles in MEM for mem_ack; 0 disables the watchdog
//  RETIRE_W       16  width of the retired-instruction counter
//  START_RUNNING  1   1: leave reset into FETCH; 0: leave reset into HALT
// PORTS
//  clock        in   1         system clock, rising edge
//  reset        in   1         asynchronous, active-low reset (0 = reset)
//  run          in   1         level; 1 = free-run, 0 = stop at next instruction boundary
//  step         in   1         1-cycle pulse; in HALT executes exactly one instruction
//  instr_op     in   3         opcode from IR, valid from DECODE onward
//  alu_zero     in   1         ALU zero flag, valid in EXEC
//  mem_ack      in   1         data-memory completion, sampled in MEM
//  ir_write     out  1         load IR from instruction memory
//  pc_write     out  1         update PC this cycle
//  pc_src       out  2         00 PC+1, 01 branch target, 10 jump target
//  reg_write    out  1         register-bank write enable
//  reg_dst      out  1         1 = rd (instr[8:6]), 0 = rt (instr[11:9])
//  alu_src      out  1         1 = imm instr[7:0], 0 = register
//  alu_op       out  2         00 add, 01 sub (beq), 10 funct-decoded
//  mem_to_reg   out  1         WB source: 1 memory, 0 ALU
//  mem_req      out  1         data-memory request, held until ack
//  mem_we       out  1         1 = store; stable while mem_req high
//  halted       out  1         FSM in HALT
//  error        out  1         sticky: watchdog expiry or illegal opcode 110
//  retired      out  RETIRE_W  retired-instruction count, wraps modulo 2^RETIRE_W
// BEHAVIOUR
//  Reset (reset=0, async): state=FETCH (START_RUNNING=1) else HALT; every strobe 0,
//   mem_req drops immediately (aborts pending access), error=0, retired=0, halted=!START_RUNNING.
//  Opcodes: 000 R-ALU, 001 addi, 010 lw, 011 sw, 100 beq, 101 j, 110 illegal, 111 halt.
//  States: HALT, FETCH, DECODE, EXEC, MEM, WB, ERROR. Outputs decoded from state + opcode only.
//  FETCH: ir_write=1, pc_write=1, pc_src=00 -> DECODE.
//  DECODE: j -> pc_write=1, pc_src=10, retire, -> boundary. halt -> retire, -> HALT.
//   110 -> error=1, -> ERROR. others -> EXEC.
//  EXEC: R: alu_src=0, alu_op=10 -> WB. addi/lw/sw: alu_src=1, alu_op=00 -> WB / MEM / MEM.
//   beq: alu_op=01; pc_write=alu_zero, pc_src=01; retire; -> boundary.
//  MEM: mem_req=1, mem_we=(sw). Stay until mem_ack=1 in the same cycle as mem_req.
//   lw -> WB; sw -> retire, -> boundary. Zero-wait ack allowed (MEM lasts 1 cycle).
//  WB: reg_write=1; reg_dst=1 for R, 0 for addi/lw; mem_to_reg=1 for lw; retire; -> boundary.
//  Latency (no wait): j 2, beq 3, R/addi/sw 4, lw 5 cycles; +1 per MEM wait cycle.
//  Boundary: run=1 and not stepping -> FETCH; else -> HALT.
//  HALT: step=1 -> FETCH with one-shot flag; flag forces HALT at next boundary. Rising edge of
//   run (registered previous value) -> FETCH. halt opcode keeps run level from re-launching;
//   only a new run rising edge or step exits. step outside HALT ignored.
//  run falls mid-instruction: instruction completes, then HALT. run+step together in HALT: step wins.
//  Watchdog: counts MEM cycles without ack; at MEM_TIMEOUT -> error=1, mem_req=0, -> ERROR.
//  ERROR: all strobes 0, halted=0; exits only via reset.
//  retired increments by 1 on each retire cycle; wraps all-ones -> 0; never on error paths.
// STRUCTURE
//  Shared include nrisc_defs.vh: opcode localparams, state encoding, pc_src and alu_op codes
//   (also consumed by ALU control and top level).
//  One sub-module: nrisc_mem_watchdog (clear on MEM entry, count while waiting, expire flag).
//  Everything else is a single FSM + output decode + retired counter in this file.
// TESTING
//  Reset then R-type 000, run=1 -> ir_write@1, reg_write,reg_dst=1 @4, retired=1, next FETCH @5.
//  lw with mem_ack delayed 3 cycles -> mem_req high 4 cycles, mem_we=0, WB @8, mem_to_reg=1.
//  beq alu_zero=1 vs 0 -> pc_write=1,pc_src=01 @3 vs pc_write=0; both retire, 3 cycles each.
//  START_RUNNING=0, step pulse, sw -> one instruction (4 cycles), halted=1 after; retired=1.
//  MEM_TIMEOUT=4, mem_ack stuck 0 -> error=1 after 4 MEM cycles, mem_req=0, stuck until reset.
//  reset=0 during MEM wait -> mem_req=0 same cycle, retired=0; opcode 111 -> HALT until run edge.

Source files
------------

// File: rtl/nrisc_mc_sequencer_pkg.sv
// rtl/nrisc_mc_sequencer_pkg.sv - shared opcode, state and datapath control codes for the nRISC sequencer
package nrisc_mc_sequencer_pkg;

    localparam logic [2:0] OP_RALU = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_J    = 3'b101;
    localparam logic [2:0] OP_ILL  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] PC_SRC_INC    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        ST_HALT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/nrisc_mem_watchdog.sv
// rtl/nrisc_mem_watchdog.sv - counts unacknowledged data-memory wait cycles and flags expiry
module nrisc_mem_watchdog #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic in_mem,
    input  logic mem_ack,
    output logic expired
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Held at zero outside MEM so every access starts counting afresh
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!in_mem || mem_ack) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Expires on the MEM_TIMEOUT-th consecutive cycle without an ack; a zero timeout never fires
    assign expired = (MEM_TIMEOUT != 0) && in_mem && !mem_ack && (wait_cnt == LAST_WAIT);

endmodule

// File: rtl/nrisc_mc_sequencer.sv
// rtl/nrisc_mc_sequencer.sv - multi-cycle control FSM driving the nRISC datapath strobes
module nrisc_mc_sequencer
    import nrisc_mc_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 15,
    parameter int RETIRE_W      = 16,
    parameter bit START_RUNNING = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic                step,
    input  logic [2:0]          instr_op,
    input  logic                alu_zero,
    input  logic                mem_ack,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic                mem_to_reg,
    output logic                mem_req,
    output logic                mem_we,
    output logic                halted,
    output logic                error,
    output logic [RETIRE_W-1:0] retired
);

    localparam state_t RESET_STATE = START_RUNNING ? ST_FETCH : ST_HALT;

    state_t     state;
    state_t     state_nx;
    logic       step_once;
    logic       step_once_nx;
    logic       run_q;
    logic       retire;
    logic       boundary;
    logic       wd_expired;

    logic       ir_write_d;
    logic       pc_write_d;
    logic [1:0] pc_src_d;
    logic       reg_write_d;
    logic       reg_dst_d;
    logic       alu_src_d;
    logic [1:0] alu_op_d;
    logic       mem_to_reg_d;
    logic       mem_req_d;
    logic       mem_we_d;

    nrisc_mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .in_mem  (state == ST_MEM),
        .mem_ack (mem_ack),
        .expired (wd_expired)
    );

    // State register, single-step flag and previous run level for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RESET_STATE;
            step_once <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            step_once <= step_once_nx;
            run_q     <= run;
        end
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + RETIRE_W'(1);
        end
    end

    // Next-state and strobe decode from current state and opcode
    always_comb begin
        state_nx     = state;
        step_once_nx = step_once;
        retire       = 1'b0;
        boundary     = 1'b0;
        ir_write_d   = 1'b0;
        pc_write_d   = 1'b0;
        pc_src_d     = PC_SRC_INC;
        reg_write_d  = 1'b0;
        reg_dst_d    = 1'b0;
        alu_src_d    = 1'b0;
        alu_op_d     = ALU_OP_ADD;
        mem_to_reg_d = 1'b0;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        case (state)
            ST_HALT: begin
                if (step) begin
                    state_nx     = ST_FETCH;
                    step_once_nx = 1'b1;
                end else if (run && !run_q) begin
                    state_nx     = ST_FETCH;
                    step_once_nx = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_write_d = 1'b1;
                pc_write_d = 1'b1;
                pc_src_d   = PC_SRC_INC;
                state_nx   = ST_DECODE;
            end
            ST_DECODE: begin
                case (instr_op)
                    OP_J: begin
                        pc_write_d = 1'b1;
                        pc_src_d   = PC_SRC_JUMP;
                        retire     = 1'b1;
                        boundary   = 1'b1;
                    end
                    OP_HALT: begin
                        retire       = 1'b1;
                        state_nx     = ST_HALT;
                        step_once_nx = 1'b0;
                    end
                    OP_ILL:  state_nx = ST_ERROR;
                    default: state_nx = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (instr_op)
                    OP_RALU: begin
                        alu_op_d = ALU_OP_FUNCT;
                        state_nx = ST_WB;
                    end
                    OP_BEQ: begin
                        alu_op_d   = ALU_OP_SUB;
                        pc_write_d = alu_zero;
                        pc_src_d   = PC_SRC_BRANCH;
                        retire     = 1'b1;
                        boundary   = 1'b1;
                    end
                    OP_ADDI: begin
                        alu_src_d = 1'b1;
                        state_nx  = ST_WB;
                    end
                    default: begin
                        alu_src_d = 1'b1;
                        state_nx  = ST_MEM;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_d = 1'b1;
                mem_we_d  = (instr_op == OP_SW);
                if (wd_expired) begin
                    state_nx = ST_ERROR;
                end else if (mem_ack) begin
                    if (instr_op == OP_SW) begin
                        retire   = 1'b1;
                        boundary = 1'b1;
                    end else begin
                        state_nx = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_write_d  = 1'b1;
                reg_dst_d    = (instr_op == OP_RALU);
                mem_to_reg_d = (instr_op == OP_LW);
                retire       = 1'b1;
                boundary     = 1'b1;
            end
            ST_ERROR: state_nx = ST_ERROR;
            default:  state_nx = ST_ERROR;
        endcase
        // A single-stepped instruction always parks in HALT, whatever run says
        if (boundary) begin
            state_nx     = (run && !step_once) ? ST_FETCH : ST_HALT;
            step_once_nx = 1'b0;
        end
    end

    // Strobes are forced low while reset is held so a pending access aborts at once
    assign ir_write   = reset && ir_write_d;
    assign pc_write   = reset && pc_write_d;
    assign pc_src     = reset ? pc_src_d : 2'b00;
    assign reg_write  = reset && reg_write_d;
    assign reg_dst    = reset && reg_dst_d;
    assign alu_src    = reset && alu_src_d;
    assign alu_op     = reset ? alu_op_d : 2'b00;
    assign mem_to_reg = reset && mem_to_reg_d;
    assign mem_req    = reset && mem_req_d;
    assign mem_we     = reset && mem_we_d;
    assign halted     = (state == ST_HALT);
    assign error      = (state == ST_ERROR);

endmodule

// File: tb/tb_nrisc_mc_sequencer.sv
// tb/tb_nrisc_mc_sequencer.sv - randomized self-checking bench for nrisc_mc_sequencer
`timescale 1ns/1ps
module tb_nrisc_mc_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       alu_zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic [2:0] instr_op = 3'd0;

    logic       a_ir_write, a_pc_write, a_reg_write, a_reg_dst, a_alu_src;
    logic       a_mem_to_reg, a_mem_req, a_mem_we, a_halted, a_error;
    logic [1:0] a_pc_src, a_alu_op;
    logic [3:0] a_retired;
    logic       h_ir_write, h_pc_write, h_reg_write, h_reg_dst, h_alu_src;
    logic       h_mem_to_reg, h_mem_req, h_mem_we, h_halted, h_error;
    logic [1:0] h_pc_src, h_alu_op;
    logic [15:0] h_retired;

    logic [13:0] a_vec, h_vec, obs_vec;
    logic [15:0] obs_ret;
    bit          sel_h = 1'b0;
    int          ret_mod = 16;
    int          m_retired = 0;
    int          total = 0;
    int          bad = 0;

    localparam logic [13:0] V_IDLE = 14'b0;
    localparam logic [13:0] V_HALT = 14'b10;
    localparam logic [13:0] V_ERR  = 14'b01;

    always #5 clock = ~clock;

    nrisc_mc_sequencer #(.MEM_TIMEOUT(4), .RETIRE_W(4), .START_RUNNING(1'b1)) dut (
        .clock(clock), .reset(reset), .run(run), .step(step), .instr_op(instr_op),
        .alu_zero(alu_zero), .mem_ack(mem_ack), .ir_write(a_ir_write), .pc_write(a_pc_write),
        .pc_src(a_pc_src), .reg_write(a_reg_write), .reg_dst(a_reg_dst), .alu_src(a_alu_src),
        .alu_op(a_alu_op), .mem_to_reg(a_mem_to_reg), .mem_req(a_mem_req), .mem_we(a_mem_we),
        .halted(a_halted), .error(a_error), .retired(a_retired)
    );

    nrisc_mc_sequencer #(.MEM_TIMEOUT(15), .RETIRE_W(16), .START_RUNNING(1'b0)) dut_h (
        .clock(clock), .reset(reset), .run(run), .step(step), .instr_op(instr_op),
        .alu_zero(alu_zero), .mem_ack(mem_ack), .ir_write(h_ir_write), .pc_write(h_pc_write),
        .pc_src(h_pc_src), .reg_write(h_reg_write), .reg_dst(h_reg_dst), .alu_src(h_alu_src),
        .alu_op(h_alu_op), .mem_to_reg(h_mem_to_reg), .mem_req(h_mem_req), .mem_we(h_mem_we),
        .halted(h_halted), .error(h_error), .retired(h_retired)
    );

    assign a_vec = {a_ir_write, a_pc_write, a_pc_src, a_reg_write, a_reg_dst, a_alu_src,
                    a_alu_op, a_mem_to_reg, a_mem_req, a_mem_we, a_halted, a_error};
    assign h_vec = {h_ir_write, h_pc_write, h_pc_src, h_reg_write, h_reg_dst, h_alu_src,
                    h_alu_op, h_mem_to_reg, h_mem_req, h_mem_we, h_halted, h_error};
    assign obs_vec = sel_h ? h_vec : a_vec;
    assign obs_ret = sel_h ? h_retired : {12'b0, a_retired};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] mk(input bit irw, input bit pcw, input logic [1:0] pcs,
                                       input bit rw, input bit rd, input bit as,
                                       input logic [1:0] ao, input bit m2r, input bit mr,
                                       input bit mw);
        return {irw, pcw, pcs, rw, rd, as, ao, m2r, mr, mw, 2'b00};
    endfunction

    // Cycles an instruction occupies: j/halt 2, beq 3, R/addi/sw 4, lw 5, plus MEM waits
    function automatic int lat(input logic [2:0] op, input int d);
        case (op)
            3'd0, 3'd1: return 4;
            3'd2:       return 5 + d;
            3'd3:       return 4 + d;
            3'd4:       return 3;
            default:    return 2;
        endcase
    endfunction

    // Expected strobes in cycle k (1 = fetch) of an instruction acked after d wait cycles
    function automatic logic [13:0] exp_at(input logic [2:0] op, input bit zero, input int d,
                                           input int k);
        bit is_mem;
        is_mem = (op == 3'd2) || (op == 3'd3);
        if (k == 1) return mk(1, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
        if (k == 2 && op == 3'd5) return mk(0, 1, 2'b10, 0, 0, 0, 2'b00, 0, 0, 0);
        if (k == 3) begin
            if (op == 3'd0) return mk(0, 0, 2'b00, 0, 0, 0, 2'b10, 0, 0, 0);
            if (op == 3'd4) return mk(0, zero, 2'b01, 0, 0, 0, 2'b01, 0, 0, 0);
            if (op <= 3'd3) return mk(0, 0, 2'b00, 0, 0, 1, 2'b00, 0, 0, 0);
        end
        if (is_mem && k >= 4 && k <= 4 + d) return mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1, op == 3'd3);
        if (op <= 3'd2 && k == lat(op, d))
            return mk(0, 0, 2'b00, 1, op == 3'd0, 0, 2'b00, op == 3'd2, 0, 0);
        return V_IDLE;
    endfunction

    // Entered just after a rising edge at the start of the fetch cycle
    task automatic do_instr(input logic [2:0] op, input bit zero, input int d,
                            input bit drop_run, input int drop_k, input bit rand_step);
        int n;
        n = lat(op, d);
        for (int k = 1; k <= n; k++) begin
            instr_op = op;
            alu_zero = zero;
            mem_ack  = ((op == 3'd2) || (op == 3'd3)) && (k == 4 + d);
            step     = rand_step ? 1'($urandom_range(0, 1)) : 1'b0;
            if (drop_run && k == drop_k) run = 1'b0;
            @(negedge clock);
            check($sformatf("op%0d_d%0d_c%0d", op, d, k), obs_vec, exp_at(op, zero, d, k));
            if (k == 1) check("retired", obs_ret, m_retired % ret_mod);
            @(posedge clock);
            #1;
        end
        mem_ack = 1'b0;
        step    = 1'b0;
        if (op != 3'd6) m_retired++;
    endtask

    task automatic idle_check(input int n, input logic [13:0] exp, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            check(tag, obs_vec, exp);
            if (k == 0) check({tag, "_ret"}, obs_ret, m_retired % ret_mod);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset(input bit run_lvl);
        reset    = 1'b0;
        run      = run_lvl;
        step     = 1'b0;
        mem_ack  = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset     = 1'b1;
        m_retired = 0;
    endtask

    initial begin
        logic [2:0] op;
        bit         zero;
        bit         drop;
        int         d;

        reset = 1'b0;
        run   = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_a_vec", a_vec, V_IDLE);
        check("rst_a_ret", {28'b0, a_retired}, 32'd0);
        check("rst_h_vec", h_vec, V_HALT);
        check("rst_h_ret", {16'b0, h_retired}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Directed openers on the free-running instance
        do_instr(3'd0, 1'b0, 0, 1'b0, 0, 1'b0);
        do_instr(3'd2, 1'b0, 3, 1'b0, 0, 1'b0);
        do_instr(3'd4, 1'b1, 0, 1'b0, 0, 1'b0);
        do_instr(3'd4, 1'b0, 0, 1'b0, 0, 1'b0);

        // Random program with stray step pulses, run drops and halt opcodes
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd6) op = 3'd0;
            zero = 1'($urandom_range(0, 1));
            d    = $urandom_range(0, 3);
            drop = (op != 3'd7) && ($urandom_range(0, 4) == 0);
            do_instr(op, zero, d, drop, $urandom_range(1, lat(op, d)), 1'b1);
            if (op == 3'd7) begin
                idle_check(3, V_HALT, "halt_hold");
                run = 1'b0;
                idle_check(1, V_HALT, "halt_runlow");
                run = 1'b1;
                idle_check(1, V_HALT, "halt_runedge");
            end else if (drop) begin
                idle_check(2, V_HALT, "drop_halt");
                run = 1'b1;
                idle_check(1, V_HALT, "drop_runedge");
            end
        end
        do_instr(3'd1, 1'b0, 0, 1'b0, 0, 1'b0);

        // Reset asserted mid MEM wait aborts the request immediately
        instr_op = 3'd2;
        mem_ack  = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        check("mem_wait_req", {31'b0, a_mem_req}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rst_abort_req", {31'b0, a_mem_req}, 32'd0);
        check("rst_abort_ret", {28'b0, a_retired}, 32'd0);

        // Watchdog: ack never arrives, four MEM cycles then ERROR for good
        @(posedge clock);
        #1;
        reset     = 1'b1;
        run       = 1'b1;
        m_retired = 0;
        for (int k = 1; k <= 7; k++) begin
            instr_op = 3'd3;
            @(negedge clock);
            check($sformatf("wd_c%0d", k), obs_vec, exp_at(3'd3, 1'b0, 100, k));
            @(posedge clock);
            #1;
        end
        step = 1'b1;
        run  = 1'b0;
        idle_check(1, V_ERR, "wd_err");
        step = 1'b0;
        run  = 1'b1;
        idle_check(3, V_ERR, "wd_stuck");

        // Illegal opcode
        do_reset(1'b1);
        do_instr(3'd6, 1'b0, 0, 1'b0, 0, 1'b0);
        idle_check(3, V_ERR, "ill_err");

        // Instance that leaves reset halted: step, then step together with run
        sel_h   = 1'b1;
        ret_mod = 65536;
        do_reset(1'b0);
        idle_check(2, V_HALT, "h_idle");
        step = 1'b1;
        idle_check(1, V_HALT, "h_step");
        step = 1'b0;
        do_instr(3'd3, 1'b0, 0, 1'b0, 0, 1'b0);
        idle_check(2, V_HALT, "h_after_sw");
        step = 1'b1;
        run  = 1'b1;
        idle_check(1, V_HALT, "h_step_run");
        step = 1'b0;
        do_instr(3'd1, 1'b0, 0, 1'b0, 0, 1'b0);
        idle_check(3, V_HALT, "h_oneshot");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
